// File: rtl/jtkcpu_useq_pkg.sv
// Shared definitions for the microcode sequencer: interrupt source codes and
// default vector categories.
package jtkcpu_useq_pkg;

  typedef enum logic [1:0] {
    INT_NONE = 2'd0,
    INT_IRQ  = 2'd1,
    INT_FIRQ = 2'd2,
    INT_NMI  = 2'd3
  } int_src_e;

  localparam int NMI_CAT_DEF  = 61;
  localparam int FIRQ_CAT_DEF = 62;
  localparam int IRQ_CAT_DEF  = 63;
  localparam int RST_CAT_DEF  = 0;

endpackage

// File: rtl/jtkcpu_useq_if.sv
// Command/status bundle between the microcode ROM/decoder (master) and the
// sequencer (slave).
interface jtkcpu_useq_if #(
  parameter int AW = 10,
  parameter int CW = 6
);
  logic          stall;
  logic          ni;
  logic [CW-1:0] cat;
  logic          jmp;
  logic          call;
  logic [CW-1:0] jcat;
  logic          ret;
  logic          skip;
  logic          nmi;
  logic          firq;
  logic          irq;
  logic          fmask;
  logic          imask;
  logic          fault;
  logic [AW-1:0] addr;
  logic          int_ack;
  logic [1:0]    int_src;
  logic          stk_err;
  logic          halted;

  modport master (
    output stall, ni, cat, jmp, call, jcat, ret, skip,
           nmi, firq, irq, fmask, imask, fault,
    input  addr, int_ack, int_src, stk_err, halted
  );

  modport slave (
    input  stall, ni, cat, jmp, call, jcat, ret, skip,
           nmi, firq, irq, fmask, imask, fault,
    output addr, int_ack, int_src, stk_err, halted
  );
endinterface

// File: rtl/jtkcpu_ustack.sv
// Small LIFO for microcode return addresses. Callers qualify push/pop; this
// block ignores a push when full and a pop when empty.
module jtkcpu_ustack #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);
  localparam int CNTW = $clog2(DEPTH + 1);

  // Rounded up to a power of two so the count can index it directly
  logic [WIDTH-1:0] mem_reg [2**CNTW];
  logic [CNTW-1:0]  cnt_reg;

  assign full  = (cnt_reg == CNTW'(DEPTH));
  assign empty = (cnt_reg == '0);
  assign top   = mem_reg[cnt_reg - CNTW'(1)];

  always_ff @(posedge clk) begin
    if (push && !full)
      mem_reg[cnt_reg] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_reg <= '0;
    else if (push && !full)
      cnt_reg <= cnt_reg + CNTW'(1);
    else if (pop && !empty)
      cnt_reg <= cnt_reg - CNTW'(1);
  end
endmodule

// File: rtl/jtkcpu_useq.sv
// Microcode address sequencer: next-address selection, call/return stack,
// interrupt vectoring on new-instruction cycles, and sticky halt on errors.
module jtkcpu_useq
  import jtkcpu_useq_pkg::*;
#(
  parameter int AW       = 10,
  parameter int CW       = 6,
  parameter int SD       = 2,
  parameter int NMI_CAT  = NMI_CAT_DEF,
  parameter int FIRQ_CAT = FIRQ_CAT_DEF,
  parameter int IRQ_CAT  = IRQ_CAT_DEF,
  parameter int RST_CAT  = RST_CAT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  jtkcpu_useq_if.slave  bus
);
  localparam logic [CW-1:0] NMI_V  = CW'(NMI_CAT);
  localparam logic [CW-1:0] FIRQ_V = CW'(FIRQ_CAT);
  localparam logic [CW-1:0] IRQ_V  = CW'(IRQ_CAT);
  localparam logic [CW-1:0] RST_V  = CW'(RST_CAT);

  function automatic logic [AW-1:0] base(input logic [CW-1:0] c);
    return {c, {(AW-CW){1'b0}}};
  endfunction

  logic [AW-1:0] addr_reg, addr_next;
  logic          nmi_last_reg, nmi_pend_reg;
  logic          int_ack_reg;
  logic [1:0]    int_src_reg, int_src_next;
  logic          stk_err_reg, halted_reg;

  logic          run;
  logic          push, pop, stk_full, stk_empty, stk_fault;
  logic          take_int, take_nmi;
  logic [AW-1:0] stk_top;

  // fault outranks stall, so it is excluded from normal sequencing here
  assign run = cen & ~halted_reg & ~bus.fault & ~bus.stall;

  always_comb begin
    addr_next    = addr_reg;
    int_src_next = int_src_reg;
    push         = 1'b0;
    pop          = 1'b0;
    stk_fault    = 1'b0;
    take_int     = 1'b0;
    take_nmi     = 1'b0;
    if (run) begin
      if (bus.ret) begin
        if (stk_empty) begin
          stk_fault = 1'b1;
        end else begin
          pop       = 1'b1;
          addr_next = stk_top;
        end
      end else if (bus.call) begin
        if (stk_full) begin
          stk_fault = 1'b1;
        end else begin
          push      = 1'b1;
          addr_next = base(bus.jcat);
        end
      end else if (bus.jmp) begin
        addr_next = base(bus.jcat);
      end else if (bus.ni) begin
        if (nmi_pend_reg) begin
          take_int     = 1'b1;
          take_nmi     = 1'b1;
          int_src_next = INT_NMI;
          addr_next    = base(NMI_V);
        end else if (bus.firq && !bus.fmask) begin
          take_int     = 1'b1;
          int_src_next = INT_FIRQ;
          addr_next    = base(FIRQ_V);
        end else if (bus.irq && !bus.imask) begin
          take_int     = 1'b1;
          int_src_next = INT_IRQ;
          addr_next    = base(IRQ_V);
        end else begin
          addr_next = base(bus.cat);
        end
      end else begin
        addr_next = addr_reg + (bus.skip ? AW'(2) : AW'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg     <= base(RST_V);
      nmi_last_reg <= 1'b0;
      nmi_pend_reg <= 1'b0;
      int_ack_reg  <= 1'b0;
      int_src_reg  <= INT_NONE;
      stk_err_reg  <= 1'b0;
      halted_reg   <= 1'b0;
    end else if (cen) begin
      addr_reg     <= addr_next;
      nmi_last_reg <= bus.nmi;
      // A fresh edge arriving while the NMI routine is entered stays pending
      nmi_pend_reg <= (bus.nmi & ~nmi_last_reg) | (nmi_pend_reg & ~take_nmi);
      int_ack_reg  <= take_int;
      int_src_reg  <= int_src_next;
      if (stk_fault)
        stk_err_reg <= 1'b1;
      if (stk_fault || bus.fault)
        halted_reg <= 1'b1;
    end
  end

  jtkcpu_ustack #(
    .DEPTH (SD),
    .WIDTH (AW)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (addr_reg + AW'(1)),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  assign bus.addr    = addr_reg;
  assign bus.int_ack = int_ack_reg;
  assign bus.int_src = int_src_reg;
  assign bus.stk_err = stk_err_reg;
  assign bus.halted  = halted_reg;
endmodule

// File: doc/jtkcpu_useq.md
JTKCPU_USEQ -- requirements
Module: jtkcpu_useq

Interface
REQ-001 SHALL have parameter AW, default 10: microcode address width.
REQ-002 SHALL have parameter CW, default 6: routine category width; routine base address = {cat, (AW-CW) zeros}.
REQ-003 SHALL have parameter SD, default 2: return-stack depth (1..8).
REQ-004 SHALL have parameters NMI_CAT/FIRQ_CAT/IRQ_CAT, defaults 61/62/63: interrupt routine categories.
REQ-005 SHALL have parameter RST_CAT, default 0: category loaded at reset.
REQ-006 Ports: clk  in  1  system clock; single clock domain.
REQ-007 Ports: rst_n  in  1  reset; asynchronous, active-low.
REQ-008 Ports: cen  in  1  clock enable; all state holds when low.
REQ-009 Ports: stall  in  1  memory/ALU/index busy; addr and stack hold, commands ignored.
REQ-010 Ports: ni  in  1  ucode "new instruction": load cat routine.
REQ-011 Ports: cat  in  CW  opcode category from decoder.
REQ-012 Ports: jmp  in  1  ucode jump to jcat routine.
REQ-013 Ports: call  in  1  ucode call: push return address, jump to jcat.
REQ-014 Ports: jcat  in  CW  jump/call target category.
REQ-015 Ports: ret  in  1  ucode return: pop stack into addr.
REQ-016 Ports: skip  in  1  advance by 2 instead of 1.
REQ-017 Ports: nmi  in  1  level; rising edge requests.
REQ-018 Ports: firq, irq  in  1 each  level-sensitive requests.
REQ-019 Ports: fmask, imask  in  1 each  high blocks firq/irq.
REQ-020 Ports: fault  in  1  ucode bus-error request; halts sequencer.
REQ-021 Ports: addr  out  AW  current ucode address (registered).
REQ-022 Ports: int_ack  out  1  one-cycle pulse when interrupt routine entered.
REQ-023 Ports: int_src  out  2  0 none, 1 irq, 2 firq, 3 nmi; valid with int_ack, held until next ack.
REQ-024 Ports: stk_err  out  1  sticky stack over/underflow.
REQ-025 Ports: halted  out  1  sticky; set by fault or stk_err.

Function
REQ-026 All updates SHALL occur on clk rising edge with cen=1; cen=0 freezes everything, including nmi edge detect.
REQ-027 With cen=1, stall=0, halted=0, next addr SHALL follow precedence: ret > call > jmp > ni > skip > +1.
REQ-028 addr arithmetic SHALL be modulo 2^AW (max address +1 wraps to 0; +2 from max-1 wraps to 0).
REQ-029 call SHALL push addr+1 (mod 2^AW) and load {jcat,0}; ret SHALL load top-of-stack and pop.
REQ-030 Push on full stack or pop on empty SHALL set stk_err and halted; addr holds; stack unchanged.
REQ-031 nmi rising edge SHALL set a pending latch, cleared only when the NMI routine is entered.
REQ-032 Interrupts SHALL be taken only on an ni cycle; priority nmi-pending > firq&!fmask > irq&!imask; selected vector category replaces cat.
REQ-033 On interrupt entry, int_ack SHALL pulse for one cen cycle and int_src SHALL update in the same cycle.
REQ-034 fault (cen=1, stall ignored) SHALL set halted; addr holds; all commands ignored until reset.
REQ-035 stall=1 SHALL not lose a pending nmi edge; edge detect continues.

Reset
REQ-036 rst_n low SHALL asynchronously set addr={RST_CAT,0}, stack empty, nmi pending/edge registers 0, int_ack 0, int_src 0, stk_err 0, halted 0.
REQ-037 Reset asserted mid-routine or mid-stall SHALL take effect immediately; first update after release on first cen edge.

Structure
REQ-038 Interrupt source encodings and default vector categories SHALL live in the shared jtkcpu package/include.
REQ-039 Return stack SHALL be a sub-module jtkcpu_ustack (parametrised depth/width, push/pop/full/empty).

Verification
REQ-040 Reset, cen=1, no commands, 5 cycles -> addr 0,1,2,3,4; skip at addr 4 -> addr 6.
REQ-041 AW=10: ni with cat=5 -> addr 0x050; addr=0x3FF, +1 -> 0x000.
REQ-042 call jcat=3 at addr 0x012 -> addr 0x030; ret -> 0x013; second ret -> stk_err=1, halted=1, addr holds 0x013.
REQ-043 irq=1, firq=1, imask=0, fmask=0, nmi pulse, then ni cat=2 -> addr {61,0}, int_src=3, int_ack one cycle; next ni -> FIRQ_CAT, int_src=2.
REQ-044 stall=1 for 3 cycles with jmp asserted -> addr unchanged; stall low -> jmp taken.
REQ-045 fault=1 -> halted=1; rst_n low async mid-cycle -> addr={RST_CAT,0}, halted=0.
